// File: rtl/y_signature_checker.sv
// Purpose : compares two Y_W-bit DUT output vectors per accepted sample and compresses y_a into a 32-bit MISR.
// Latency : one clk from an accepted sample to every result output; busy/done follow the state register.
// Backpressure: none; samples are taken whenever sample_valid is high in RUN and ignored otherwise.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   start               begin a new run from IDLE or DONE (ignored while running)
//   sample_valid        y_a/y_b carry a sample this cycle
//   y_a, y_b            behavioural and synthesized DUT outputs
//   busy, done          run in progress / run complete with results held
//   signature           running MISR of y_a
//   mismatch            sticky, any accepted sample had y_a != y_b
//   mismatch_count      number of mismatching samples (saturating)
//   first_mismatch_idx  0-based index of the first mismatch, 16'hFFFF if none
//   sample_count        samples accepted in the current run
module y_signature_checker #(
  parameter int          Y_W         = 501,
  parameter int          NUM_SAMPLES = 21,
  parameter logic [31:0] SEED        = 32'hFFFFFFFF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           sample_valid,
  input  logic [Y_W-1:0] y_a,
  input  logic [Y_W-1:0] y_b,
  output logic           busy,
  output logic           done,
  output logic [31:0]    signature,
  output logic           mismatch,
  output logic [15:0]    mismatch_count,
  output logic [15:0]    first_mismatch_idx,
  output logic [15:0]    sample_count
);

  localparam logic [31:0] POLY     = 32'h04C11DB7;
  localparam logic [15:0] LAST_IDX = 16'(NUM_SAMPLES - 1);
  localparam logic [15:0] NO_IDX   = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state;
  state_t       state_nxt;
  logic         launch;
  logic         accept;
  logic [511:0] y_ext;
  logic [31:0]  fold;
  logic [31:0]  sig_nxt;
  logic         differ;

  // y_a padded to 16 whole 32-bit chunks, then XOR-folded to one word.
  always_comb begin
    y_ext          = '0;
    y_ext[Y_W-1:0] = y_a;
    fold           = '0;
    for (int i = 0; i < 16; i++) begin
      fold = fold ^ y_ext[i*32 +: 32];
    end
  end

  assign sig_nxt = {signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'h0) ^ fold;
  assign differ  = (y_a != y_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // start has priority over sample_valid outside RUN; start inside RUN is ignored.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (sample_valid) begin
          accept = 1'b1;
          // Final sample is still fully accounted on the same edge that enters DONE.
          if (sample_count == LAST_IDX) begin
            state_nxt = DONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature          <= SEED;
      sample_count       <= '0;
      mismatch_count     <= '0;
      mismatch           <= 1'b0;
      first_mismatch_idx <= NO_IDX;
    end else if (launch) begin
      signature          <= SEED;
      sample_count       <= '0;
      mismatch_count     <= '0;
      mismatch           <= 1'b0;
      first_mismatch_idx <= NO_IDX;
    end else if (accept) begin
      signature    <= sig_nxt;
      sample_count <= sample_count + 16'd1;
      if (differ) begin
        mismatch <= 1'b1;
        if (mismatch_count != 16'hFFFF) begin
          mismatch_count <= mismatch_count + 16'd1;
        end
        // Index is the pre-increment count, i.e. the 0-based sample number.
        if (first_mismatch_idx == NO_IDX) begin
          first_mismatch_idx <= sample_count;
        end
      end
    end
  end

endmodule

// File: tb/tb_y_signature_checker.sv
// Bench for y_signature_checker: a default-parameter instance (u0) and a NUM_SAMPLES=1 instance (u1)
// share clock, reset and sample inputs; each has its own start. Directed vectors, inline checks.
module tb_y_signature_checker;

  localparam int          Y_W  = 501;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic           clk          = 1'b0;
  logic           rst_n        = 1'b0;
  logic           start0       = 1'b0;
  logic           start1       = 1'b0;
  logic           sample_valid = 1'b0;
  logic [Y_W-1:0] y_a          = '0;
  logic [Y_W-1:0] y_b          = '0;

  logic        busy0, done0, mm0, busy1, done1, mm1;
  logic [31:0] sig0, sig1;
  logic [15:0] mcnt0, fmi0, scnt0, mcnt1, fmi1, scnt1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  y_signature_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .sample_valid(sample_valid),
    .y_a(y_a), .y_b(y_b), .busy(busy0), .done(done0), .signature(sig0),
    .mismatch(mm0), .mismatch_count(mcnt0), .first_mismatch_idx(fmi0), .sample_count(scnt0)
  );

  y_signature_checker #(.Y_W(Y_W), .NUM_SAMPLES(1), .SEED(SEED)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sample_valid(sample_valid),
    .y_a(y_a), .y_b(y_b), .busy(busy1), .done(done1), .signature(sig1),
    .mismatch(mm1), .mismatch_count(mcnt1), .first_mismatch_idx(fmi1), .sample_count(scnt1)
  );

  // Deterministic per-sample pattern.
  function automatic logic [Y_W-1:0] gen_y(input int i);
    logic [Y_W-1:0] y;
    for (int b = 0; b < Y_W; b++) y[b] = ((((b * (i + 3)) + i) % 7) < 3);
    return y;
  endfunction

  // y_b differs from y_a at sample 5 (bit 500) and sample 12 (bit 0).
  function automatic logic [Y_W-1:0] gen_yb(input int i);
    logic [Y_W-1:0] y;
    y = gen_y(i);
    if (i == 5)  y[500] = ~y[500];
    if (i == 12) y[0]   = ~y[0];
    return y;
  endfunction

  // Reference MISR step: bit b of y lands in fold bit b mod 32.
  function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [Y_W-1:0] y);
    logic [31:0] f;
    f = '0;
    for (int b = 0; b < Y_W; b++) f[5'(b % 32)] = f[5'(b % 32)] ^ y[b];
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  function automatic logic [31:0] exp_sig(input int n);
    logic [31:0] s;
    s = SEED;
    for (int i = 0; i < n; i++) s = sig_step(s, gen_y(i));
    return s;
  endfunction

  task automatic begin_run0();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
  endtask

  task automatic begin_run1();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
  endtask

  // Drive samples first..last-1 to u0; optional idle cycle after each; start pulsed with sample start_at.
  task automatic feed0(input int first, input int last, input bit toggle, input int start_at);
    for (int i = first; i < last; i++) begin
      @(negedge clk);
      start0       = (i == start_at);
      sample_valid = 1'b1;
      y_a          = gen_y(i);
      y_b          = gen_yb(i);
      if (toggle) begin
        @(negedge clk);
        start0       = 1'b0;
        sample_valid = 1'b0;
        y_a          = ~y_a;
        y_b          = '0;
      end
    end
    @(negedge clk);
    sample_valid = 1'b0;
    start0       = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done0); end
    vectors++; if (sig0 !== SEED) begin miscompares++; $display("FAIL reset_sig: got %h expected %h", sig0, SEED); end
    vectors++; if (scnt0 !== 16'd0) begin miscompares++; $display("FAIL reset_scnt: got %h expected 0", scnt0); end
    vectors++; if (mcnt0 !== 16'd0 || mm0 !== 1'b0) begin miscompares++; $display("FAIL reset_mm: got cnt %h flag %b expected 0/0", mcnt0, mm0); end
    vectors++; if (fmi0 !== 16'hFFFF) begin miscompares++; $display("FAIL reset_fmi: got %h expected ffff", fmi0); end
    vectors++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin miscompares++; $display("FAIL reset_u1_state: got busy %b done %b expected 0/0", busy1, done1); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single_zero();
    begin_run1();
    vectors++; if (busy1 !== 1'b1 || sig1 !== SEED) begin miscompares++; $display("FAIL single_start: got busy %b sig %h expected 1/%h", busy1, sig1, SEED); end
    sample_valid = 1'b1; y_a = '0; y_b = '0;
    @(negedge clk); sample_valid = 1'b0;
    vectors++; if (sig1 !== 32'hFB3EE249) begin miscompares++; $display("FAIL single_zero_sig: got %h expected fb3ee249", sig1); end
    vectors++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin miscompares++; $display("FAIL single_zero_done: got done %b busy %b expected 1/0", done1, busy1); end
    vectors++; if (mm1 !== 1'b0 || fmi1 !== 16'hFFFF) begin miscompares++; $display("FAIL single_zero_mm: got %b/%h expected 0/ffff", mm1, fmi1); end
    vectors++; if (scnt1 !== 16'd1) begin miscompares++; $display("FAIL single_zero_scnt: got %h expected 1", scnt1); end
  endtask

  task automatic test_single_ones();
    begin_run1();
    vectors++; if (scnt1 !== 16'd0 || sig1 !== SEED) begin miscompares++; $display("FAIL ones_restart: got cnt %h sig %h expected 0/%h", scnt1, sig1, SEED); end
    sample_valid = 1'b1; y_a = '1; y_b = '1;
    @(negedge clk); sample_valid = 1'b0;
    vectors++; if (sig1 !== 32'h04DEE249) begin miscompares++; $display("FAIL ones_sig: got %h expected 04dee249", sig1); end
    vectors++; if (mm1 !== 1'b0 || done1 !== 1'b1) begin miscompares++; $display("FAIL ones_flags: got mm %b done %b expected 0/1", mm1, done1); end
  endtask

  task automatic test_full_run();
    logic [31:0] e;
    e = exp_sig(21);
    begin_run0();
    feed0(0, 6, 1'b0, -1);
    vectors++; if (mm0 !== 1'b1 || fmi0 !== 16'd5) begin miscompares++; $display("FAIL full_first_mm: got %b/%h expected 1/0005", mm0, fmi0); end
    vectors++; if (mcnt0 !== 16'd1 || scnt0 !== 16'd6 || busy0 !== 1'b1) begin miscompares++; $display("FAIL full_mid: got mcnt %h scnt %h busy %b expected 1/6/1", mcnt0, scnt0, busy0); end
    vectors++; if (sig0 !== exp_sig(6)) begin miscompares++; $display("FAIL full_mid_sig: got %h expected %h", sig0, exp_sig(6)); end
    feed0(6, 21, 1'b0, -1);
    vectors++; if (done0 !== 1'b1 || busy0 !== 1'b0) begin miscompares++; $display("FAIL full_done: got done %b busy %b expected 1/0", done0, busy0); end
    vectors++; if (mcnt0 !== 16'd2 || fmi0 !== 16'd5 || mm0 !== 1'b1) begin miscompares++; $display("FAIL full_mm: got cnt %h fmi %h flag %b expected 2/5/1", mcnt0, fmi0, mm0); end
    vectors++; if (scnt0 !== 16'd21) begin miscompares++; $display("FAIL full_scnt: got %0d expected 21", scnt0); end
    vectors++; if (sig0 !== e) begin miscompares++; $display("FAIL full_sig: got %h expected %h", sig0, e); end
    // DONE ignores further samples.
    sample_valid = 1'b1; y_a = gen_y(3); y_b = '0;
    repeat (2) @(negedge clk);
    sample_valid = 1'b0;
    vectors++; if (sig0 !== e || scnt0 !== 16'd21 || mcnt0 !== 16'd2) begin miscompares++; $display("FAIL done_hold: got sig %h scnt %0d mcnt %0d expected %h/21/2", sig0, scnt0, mcnt0, e); end
  endtask

  task automatic test_toggle_valid();
    begin_run0();
    feed0(0, 20, 1'b1, 7);
    vectors++; if (busy0 !== 1'b1 || done0 !== 1'b0 || scnt0 !== 16'd20) begin miscompares++; $display("FAIL toggle_20: got busy %b done %b scnt %0d expected 1/0/20", busy0, done0, scnt0); end
    feed0(20, 21, 1'b1, -1);
    vectors++; if (done0 !== 1'b1 || scnt0 !== 16'd21) begin miscompares++; $display("FAIL toggle_done: got done %b scnt %0d expected 1/21", done0, scnt0); end
    vectors++; if (sig0 !== exp_sig(21)) begin miscompares++; $display("FAIL toggle_sig: got %h expected %h", sig0, exp_sig(21)); end
    vectors++; if (mcnt0 !== 16'd2 || fmi0 !== 16'd5) begin miscompares++; $display("FAIL toggle_mm: got %h/%h expected 2/5", mcnt0, fmi0); end
  endtask

  task automatic test_start_with_valid();
    @(negedge clk);
    start0 = 1'b1; sample_valid = 1'b1; y_a = gen_y(0); y_b = ~gen_y(0);
    @(negedge clk);
    start0 = 1'b0; sample_valid = 1'b0;
    vectors++; if (scnt0 !== 16'd0 || sig0 !== SEED) begin miscompares++; $display("FAIL start_valid_clear: got scnt %h sig %h expected 0/%h", scnt0, sig0, SEED); end
    vectors++; if (busy0 !== 1'b1 || mm0 !== 1'b0 || mcnt0 !== 16'd0 || fmi0 !== 16'hFFFF) begin miscompares++; $display("FAIL start_valid_state: got busy %b mm %b mcnt %h fmi %h expected 1/0/0/ffff", busy0, mm0, mcnt0, fmi0); end
  endtask

  task automatic test_reset_midrun();
    begin_run0();
    feed0(0, 10, 1'b0, -1);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin miscompares++; $display("FAIL arst_state: got busy %b done %b expected 0/0", busy0, done0); end
    vectors++; if (sig0 !== SEED || scnt0 !== 16'd0) begin miscompares++; $display("FAIL arst_sig: got sig %h scnt %h expected %h/0", sig0, scnt0, SEED); end
    vectors++; if (mm0 !== 1'b0 || mcnt0 !== 16'd0 || fmi0 !== 16'hFFFF) begin miscompares++; $display("FAIL arst_mm: got %b/%h/%h expected 0/0/ffff", mm0, mcnt0, fmi0); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); sample_valid = 1'b1; y_a = gen_y(1); y_b = gen_y(1);
    @(negedge clk); sample_valid = 1'b0;
    vectors++; if (busy0 !== 1'b0 || scnt0 !== 16'd0) begin miscompares++; $display("FAIL arst_idle: got busy %b scnt %h expected 0/0", busy0, scnt0); end
    begin_run0();
    feed0(0, 21, 1'b0, -1);
    vectors++; if (done0 !== 1'b1 || sig0 !== exp_sig(21)) begin miscompares++; $display("FAIL rerun_sig: got done %b sig %h expected 1/%h", done0, sig0, exp_sig(21)); end
    vectors++; if (mcnt0 !== 16'd2 || fmi0 !== 16'd5 || scnt0 !== 16'd21) begin miscompares++; $display("FAIL rerun_mm: got %h/%h/%0d expected 2/5/21", mcnt0, fmi0, scnt0); end
  endtask

  initial begin
    test_reset();
    test_single_zero();
    test_single_ones();
    test_full_run();
    test_toggle_valid();
    test_start_with_valid();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/y_signature_checker.md
Y_SIGNATURE_CHECKER -- requirements
Module: y_signature_checker

Interface
REQ-001 Parameter Y_W, default 501, width of each compared DUT output vector.
REQ-002 Parameter NUM_SAMPLES, default 21, number of accepted samples per run (range 1..65535).
REQ-003 Parameter SEED, default 32'hFFFFFFFF, initial signature value.
REQ-004 Port clk  input  1  sole clock; all state updates on posedge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  begins a run (clears accumulators) when in IDLE or DONE.
REQ-007 Port sample_valid  input  1  y_a/y_b hold a sample to accept this cycle.
REQ-008 Port y_a  input  Y_W  output vector of the behavioural (identity) DUT.
REQ-009 Port y_b  input  Y_W  output vector of the synthesized DUT.
REQ-010 Port busy  output  1  high while in RUN.
REQ-011 Port done  output  1  high while in DONE.
REQ-012 Port signature  output  32  running MISR signature of y_a.
REQ-013 Port mismatch  output  1  sticky; high once any accepted sample had y_a != y_b.
REQ-014 Port mismatch_count  output  16  number of mismatching samples, saturating.
REQ-015 Port first_mismatch_idx  output  16  sample index (0-based) of first mismatch; 16'hFFFF if none.
REQ-016 Port sample_count  output  16  samples accepted in current run.

Function
REQ-017 FSM states IDLE, RUN, DONE; all outputs registered, no combinational input-to-output paths.
REQ-018 IDLE or DONE with start=1: next state RUN; signature<=SEED, sample_count<=0, mismatch_count<=0, mismatch<=0, first_mismatch_idx<=16'hFFFF.
REQ-019 start while in RUN is ignored; run continues unchanged.
REQ-020 Sample accepted only when state==RUN and sample_valid=1; sample_valid outside RUN ignored.
REQ-021 Fold: y_a zero-extended to 512 bits, split into 16 32-bit chunks, fold = XOR of all chunks.
REQ-022 On accept: signature <= (signature<<1) ^ (signature[31] ? 32'h04C11DB7 : 0) ^ fold; visible the cycle after accept.
REQ-023 On accept: sample_count increments by 1.
REQ-024 On accept with y_a != y_b (full Y_W compare): mismatch<=1; mismatch_count increments, saturating at 16'hFFFF; if first_mismatch_idx==16'hFFFF it takes the pre-increment sample_count.
REQ-025 Accept that brings sample_count to NUM_SAMPLES moves RUN->DONE in the same edge; that sample is fully accounted.
REQ-026 DONE holds all result outputs stable until start or reset; further sample_valid has no effect.
REQ-027 start and sample_valid together in IDLE/DONE: start wins, sample not accepted.
REQ-028 Latency: one clk from accept to all updated outputs; busy/done change on the same edge as the state.

Reset
REQ-029 rst_n=0 immediately forces IDLE, busy=0, done=0, signature=SEED, sample_count=0, mismatch_count=0, mismatch=0, first_mismatch_idx=16'hFFFF, regardless of clk.
REQ-030 Reset asserted mid-run discards the run; after release the block waits in IDLE for start.

Verification
REQ-031 NUM_SAMPLES=1, start, one accept y_a=y_b=0 -> signature=32'hFB3EE249, done=1, mismatch=0, first_mismatch_idx=16'hFFFF.
REQ-032 NUM_SAMPLES=1, accept y_a=y_b=all-ones -> fold=32'hFFE00000, signature=32'h04DEE249, mismatch=0.
REQ-033 Default params, 21 accepts with y_a=y_b except sample 5 (y_b bit 500 flipped) and sample 12 -> mismatch=1, mismatch_count=2, first_mismatch_idx=5, sample_count=21, done=1.
REQ-034 sample_valid toggled 1/0 per cycle during RUN -> only high cycles counted; DONE after 21st high cycle; start pulsed mid-run has no effect.
REQ-035 rst_n low between clk edges at sample 10 -> outputs at reset values without a clk edge; after release start gives fresh run identical to an uninterrupted one.
REQ-036 Start in DONE with sample_valid=1 same cycle -> counters cleared, sample_count=0 next cycle, signature=SEED.
